// File: rtl/semaphore_access_initiator_if.sv
// Command/response and semaphore-array handshake bundle of one core's initiator.
// master = the initiator; slave = the core/array side driving commands and ready flags.
interface semaphore_access_initiator_if #(
  parameter int ADDR_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic              rsp_valid;
  logic [1:0]        rsp_code;
  logic              held_valid;
  logic [ADDR_W-1:0] held_addr;
  logic [ADDR_W-1:0] WR_Addr;
  logic              WR_EN;
  logic              WR;
  logic              WR_RDY;
  logic [ADDR_W-1:0] RD_Addr;
  logic              RD_EN;
  logic              RD;
  logic              RD_Release;
  logic              RD_RDY;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, WR_RDY, RD_RDY,
    output cmd_ready, rsp_valid, rsp_code, held_valid, held_addr,
           WR_Addr, WR_EN, WR, RD_Addr, RD_EN, RD, RD_Release
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, WR_RDY, RD_RDY,
    input  cmd_ready, rsp_valid, rsp_code, held_valid, held_addr,
           WR_Addr, WR_EN, WR, RD_Addr, RD_EN, RD, RD_Release
  );
endinterface

// File: rtl/semaphore_access_initiator.sv
// One-command-at-a-time WRITE/ACQUIRE/RELEASE initiator; response 3 cycles after accept (2 for
// RELEASE, 1 for errors) when ready is high; waits up to TIMEOUT cycles; cmd_ready only in IDLE.
module semaphore_access_initiator #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input logic                   clk,
  input logic                   rst,
  semaphore_access_initiator_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, WR_WAIT, WR_PULSE, RD_WAIT, RD_PULSE, REL_PULSE, RESP
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_ACQ   = 2'b01;
  localparam logic [1:0] OP_REL   = 2'b10;
  localparam logic [1:0] OP_RSV   = 2'b11;

  localparam logic [1:0] RC_OK    = 2'b00;
  localparam logic [1:0] RC_TMO   = 2'b01;
  localparam logic [1:0] RC_BAD   = 2'b10;
  localparam logic [1:0] RC_LOCK  = 2'b11;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [1:0]        code_q, code_d;
  logic              held_valid_q, held_valid_d;
  logic [ADDR_W-1:0] held_addr_q, held_addr_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_code_q, rsp_code_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              rd_q, rd_d;
  logic              rd_rel_q, rd_rel_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    held_valid_d = held_valid_q;
    held_addr_d  = held_addr_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          addr_d = bus.cmd_addr;
          cnt_d  = '0;
          code_d = RC_OK;
          if (bus.cmd_addr == '0 || bus.cmd_op == OP_RSV) begin
            state_d = RESP;
            code_d  = RC_BAD;
          end else if (bus.cmd_op == OP_ACQ && held_valid_q) begin
            state_d = RESP;
            code_d  = RC_LOCK;
          end else if (bus.cmd_op == OP_REL &&
                       (!held_valid_q || bus.cmd_addr != held_addr_q)) begin
            state_d = RESP;
            code_d  = RC_LOCK;
          end else begin
            case (bus.cmd_op)
              OP_WRITE: state_d = WR_WAIT;
              OP_ACQ:   state_d = RD_WAIT;
              default:  state_d = REL_PULSE;
            endcase
          end
        end
      end
      WR_WAIT: begin
        // A ready flag in the last allowed wait cycle still wins over the timeout.
        if (bus.WR_RDY) begin
          state_d = WR_PULSE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          code_d  = RC_TMO;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      WR_PULSE: begin
        state_d = RESP;
        code_d  = RC_OK;
      end
      RD_WAIT: begin
        if (bus.RD_RDY) begin
          state_d = RD_PULSE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          code_d  = RC_TMO;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      RD_PULSE: begin
        held_valid_d = 1'b1;
        held_addr_d  = addr_q;
        state_d      = RESP;
        code_d       = RC_OK;
      end
      REL_PULSE: begin
        held_valid_d = 1'b0;
        held_addr_d  = '0;
        state_d      = RESP;
        code_d       = RC_OK;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so every port comes straight from a flop.
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_code_d  = (state_d == RESP) ? code_d : RC_OK;
    wr_en_d     = (state_d == WR_WAIT) || (state_d == WR_PULSE);
    wr_d        = (state_d == WR_PULSE);
    wr_addr_d   = wr_en_d ? addr_d : '0;
    rd_en_d     = (state_d == RD_WAIT) || (state_d == RD_PULSE) || (state_d == REL_PULSE);
    rd_d        = (state_d == RD_PULSE);
    rd_rel_d    = (state_d == REL_PULSE);
    rd_addr_d   = !rd_en_d ? '0 : (state_d == REL_PULSE) ? held_addr_q : addr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      code_q       <= RC_OK;
      held_valid_q <= 1'b0;
      held_addr_q  <= '0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_code_q   <= RC_OK;
      wr_en_q      <= 1'b0;
      wr_q         <= 1'b0;
      wr_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      rd_q         <= 1'b0;
      rd_rel_q     <= 1'b0;
      rd_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      held_valid_q <= held_valid_d;
      held_addr_q  <= held_addr_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_code_q   <= rsp_code_d;
      wr_en_q      <= wr_en_d;
      wr_q         <= wr_d;
      wr_addr_q    <= wr_addr_d;
      rd_en_q      <= rd_en_d;
      rd_q         <= rd_d;
      rd_rel_q     <= rd_rel_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_code   = rsp_code_q;
  assign bus.held_valid = held_valid_q;
  assign bus.held_addr  = held_addr_q;
  assign bus.WR_EN      = wr_en_q;
  assign bus.WR         = wr_q;
  assign bus.WR_Addr    = wr_addr_q;
  assign bus.RD_EN      = rd_en_q;
  assign bus.RD         = rd_q;
  assign bus.RD_Release = rd_rel_q;
  assign bus.RD_Addr    = rd_addr_q;

endmodule

// File: tb/tb_semaphore_access_initiator.sv
// Bench: per-command expected output timelines derived from wait length and lock rules,
// compared against the DUT on every negedge, plus literal latency/count expectations.
module tb_semaphore_access_initiator;
  localparam int AW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  semaphore_access_initiator_if #(.ADDR_W(AW)) bus ();

  semaphore_access_initiator #(.ADDR_W(AW), .TIMEOUT(TO), .TO_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic          cmd_ready;
    logic          rsp_valid;
    logic [1:0]    rsp_code;
    logic          held_valid;
    logic [AW-1:0] held_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd;
    logic          rd_rel;
  } vec_t;

  vec_t          exp_q[$];
  bit            m_held_v;
  logic [AW-1:0] m_held_a;
  int            n_vec = 0;
  int            n_err = 0;
  bit            chk_en = 1'b0;
  int            cyc = 0;
  int            n_rsp = 0, n_wr = 0, n_rd = 0, n_rel = 0, n_wren = 0;
  logic [1:0]    last_code;
  int            rsp_cyc, acc_cyc;
  int            d_rsp, d_wr, d_rd, d_rel, d_wren, lat;
  vec_t          cmp_e, cmp_a;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t idle_vec();
    vec_t v;
    v            = '0;
    v.cmd_ready  = 1'b1;
    v.held_valid = m_held_v;
    v.held_addr  = m_held_a;
    return v;
  endfunction

  function automatic vec_t dut_vec();
    vec_t v;
    v.cmd_ready  = bus.cmd_ready;
    v.rsp_valid  = bus.rsp_valid;
    v.rsp_code   = bus.rsp_code;
    v.held_valid = bus.held_valid;
    v.held_addr  = bus.held_addr;
    v.wr_en      = bus.WR_EN;
    v.wr_addr    = bus.WR_Addr;
    v.wr         = bus.WR;
    v.rd_en      = bus.RD_EN;
    v.rd_addr    = bus.RD_Addr;
    v.rd         = bus.RD;
    v.rd_rel     = bus.RD_Release;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_a = dut_vec();
      if (exp_q.size() > 0) cmp_e = exp_q.pop_front();
      else                  cmp_e = idle_vec();
      chk("cycle", 32'(cmp_a), 32'(cmp_e));
      chk("strobe_excl", 32'($countones({cmp_a.wr, cmp_a.rd, cmp_a.rd_rel}) <= 1), 32'd1);
      chk("addr_zero", 32'((cmp_a.wr_en || cmp_a.wr_addr == '0) &&
                           (cmp_a.rd_en || cmp_a.rd_addr == '0)), 32'd1);
      if (cmp_a.rsp_valid) begin
        n_rsp++;
        last_code = cmp_a.rsp_code;
        rsp_cyc   = cyc;
      end
      if (cmp_a.wr)     n_wr++;
      if (cmp_a.rd)     n_rd++;
      if (cmp_a.rd_rel) n_rel++;
      if (cmp_a.wr_en)  n_wren++;
    end
  end

  // Expected timeline: wait cycles = d+1 if ready arrives in time, else TIMEOUT.
  task automatic model_push(input logic [1:0] op, input logic [AW-1:0] addr, input int d);
    vec_t b, v;
    bit   ok;
    b            = '0;
    b.held_valid = m_held_v;
    b.held_addr  = m_held_a;
    v            = b;
    v.rsp_valid  = 1'b1;
    if (addr == 0 || op == 2'd3) begin
      v.rsp_code = 2'd2;
      exp_q.push_back(v);
    end else if (op == 2'd1 && m_held_v) begin
      v.rsp_code = 2'd3;
      exp_q.push_back(v);
    end else if (op == 2'd2 && (!m_held_v || addr != m_held_a)) begin
      v.rsp_code = 2'd3;
      exp_q.push_back(v);
    end else if (op == 2'd2) begin
      v         = b;
      v.rd_en   = 1'b1;
      v.rd_addr = addr;
      v.rd_rel  = 1'b1;
      exp_q.push_back(v);
      m_held_v  = 1'b0;
      m_held_a  = '0;
      v         = '0;
      v.rsp_valid = 1'b1;
      exp_q.push_back(v);
    end else begin
      ok = (d < TO);
      v  = b;
      if (op == 2'd0) begin v.wr_en = 1'b1; v.wr_addr = addr; end
      else            begin v.rd_en = 1'b1; v.rd_addr = addr; end
      repeat (ok ? d + 1 : TO) exp_q.push_back(v);
      if (ok) begin
        if (op == 2'd0) v.wr = 1'b1;
        else            v.rd = 1'b1;
        exp_q.push_back(v);
        if (op == 2'd1) begin m_held_v = 1'b1; m_held_a = addr; end
      end
      v            = '0;
      v.held_valid = m_held_v;
      v.held_addr  = m_held_a;
      v.rsp_valid  = 1'b1;
      v.rsp_code   = ok ? 2'd0 : 2'd1;
      exp_q.push_back(v);
    end
  endtask

  // Called #1 after a rising edge; rst_at>0 asserts reset in that cycle after accept.
  task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input int d,
                        input int rst_at);
    int k, guard, rsp0, wr0, rd0, rel0, wren0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    rsp0 = n_rsp; wr0 = n_wr; rd0 = n_rd; rel0 = n_rel; wren0 = n_wren;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_addr  = AW'($urandom);
    acc_cyc = cyc;
    model_push(op, addr, d);
    k = 1;
    while (exp_q.size() != 0) begin
      if (k == rst_at) begin
        rst = 1'b1;
        bus.WR_RDY = 1'b0;
        bus.RD_RDY = 1'b0;
        @(negedge clk); #1;
        exp_q.delete();
        m_held_v = 1'b0;
        m_held_a = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
      if (op == 2'd0) begin bus.WR_RDY = (k > d); bus.RD_RDY = 1'($urandom); end
      else            begin bus.RD_RDY = (k > d); bus.WR_RDY = 1'($urandom); end
      @(posedge clk); #1;
      k++;
      if (k > 300) begin
        chk("op_bound", 32'(k), 32'd0);
        exp_q.delete();
        break;
      end
    end
    bus.WR_RDY = 1'b0;
    bus.RD_RDY = 1'b0;
    d_rsp  = n_rsp - rsp0;
    d_wr   = n_wr - wr0;
    d_rd   = n_rd - rd0;
    d_rel  = n_rel - rel0;
    d_wren = n_wren - wren0;
    lat    = rsp_cyc - acc_cyc + 1;
    chk("rsp_count", 32'(d_rsp), (rst_at > 0) ? 32'd0 : 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    logic [1:0] rop;
    logic [AW-1:0] raddr;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_addr  = '0;
    bus.WR_RDY    = 1'b0;
    bus.RD_RDY    = 1'b0;
    m_held_v = 1'b0;
    m_held_a = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    rv = '0;
    rv.cmd_ready = 1'b1;
    chk("reset_outputs", 32'(dut_vec()), 32'(rv));
    #1 chk_en = 1'b1;
    @(posedge clk); #1;

    do_cmd(2'd0, 4'd5, 0, 0);
    chk("w5_latency", 32'(lat), 32'd3);
    chk("w5_wr_pulses", 32'(d_wr), 32'd1);
    chk("w5_wr_en_cycles", 32'(d_wren), 32'd2);
    chk("w5_code", 32'(last_code), 32'd0);

    do_cmd(2'd1, 4'd3, 4, 0);
    chk("a3_latency", 32'(lat), 32'd7);
    chk("a3_rd_pulses", 32'(d_rd), 32'd1);
    chk("a3_held", 32'({bus.held_valid, bus.held_addr}), 32'h13);
    do_cmd(2'd2, 4'd3, 0, 0);
    chk("r3_latency", 32'(lat), 32'd2);
    chk("r3_rel_pulses", 32'(d_rel), 32'd1);
    chk("r3_held", 32'({bus.held_valid, bus.held_addr}), 32'h00);

    do_cmd(2'd0, 4'd7, 1000, 0);
    chk("w7_to_wr_en_cycles", 32'(d_wren), 32'd8);
    chk("w7_to_wr_pulses", 32'(d_wr), 32'd0);
    chk("w7_to_code", 32'(last_code), 32'd1);
    do_cmd(2'd0, 4'd7, 7, 0);
    chk("w7_late_wr_pulses", 32'(d_wr), 32'd1);
    chk("w7_late_code", 32'(last_code), 32'd0);

    do_cmd(2'd0, 4'd0, 0, 0);
    chk("bad_addr_code", 32'(last_code), 32'd2);
    chk("bad_addr_latency", 32'(lat), 32'd1);
    do_cmd(2'd3, 4'd6, 0, 0);
    chk("bad_op_code", 32'(last_code), 32'd2);
    do_cmd(2'd2, 4'd4, 0, 0);
    chk("rel_none_code", 32'(last_code), 32'd3);
    do_cmd(2'd1, 4'd9, 0, 0);
    do_cmd(2'd1, 4'd2, 0, 0);
    chk("acq_held_code", 32'(last_code), 32'd3);
    chk("acq_held_latency", 32'(lat), 32'd1);
    do_cmd(2'd2, 4'd4, 0, 0);
    chk("rel_wrong_code", 32'(last_code), 32'd3);
    chk("rel_wrong_strobes", 32'(d_rd + d_rel + d_wren), 32'd0);
    do_cmd(2'd0, 4'd9, 2, 0);
    chk("w_held_code", 32'(last_code), 32'd0);
    do_cmd(2'd2, 4'd9, 0, 0);

    rv = '0;
    rv.cmd_ready = 1'b1;
    do_cmd(2'd1, 4'd6, 1000, 2);
    chk("rst_wait_outputs", 32'(dut_vec()), 32'(rv));
    do_cmd(2'd1, 4'd6, 0, 2);
    chk("rst_pulse_outputs", 32'(dut_vec()), 32'(rv));
    chk("rst_pulse_rd_seen", 32'(d_rd), 32'd1);

    for (int i = 0; i < 20; i++) begin
      rop   = 2'($urandom_range(0, 3));
      raddr = AW'($urandom_range(0, 15));
      if (rop == 2'd2 && m_held_v && $urandom_range(0, 1) == 1) raddr = m_held_a;
      do_cmd(rop, raddr, $urandom_range(0, 10), 0);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
